// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl: valid/ready FIFO controller in front of a dual-port RAM with a 2-entry read buffer.
// Optional high-water-mark tracking is enabled by defining DPRAM_FIFO_HWM_EN.
module dpram_fifo_ctrl #(
  parameter int data_width = 8,
  parameter int addr_width = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [data_width-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [data_width-1:0] m_data,
  output logic                  ram_a,
  output logic [addr_width-1:0] ram_addr_a,
  output logic [data_width-1:0] ram_data_a,
  output logic                  ram_b,
  output logic [addr_width-1:0] ram_addr_b,
  input  logic [data_width-1:0] ram_rdata_b,
  output logic [addr_width+1:0] count,
  output logic                  full,
  output logic                  empty
`ifdef DPRAM_FIFO_HWM_EN
  ,
  input  logic                  hwm_clr,
  output logic [addr_width+1:0] hwm
`endif
);
  logic [addr_width:0]   r_wr_ptr, r_rd_ptr;
  logic                  r_inflight;
  logic [1:0]            r_buf_cnt;
  logic [data_width-1:0] r_buf0, r_buf1;
  logic [addr_width:0]   w_mem_cnt;
  logic                  w_push, w_pop, w_issue;
  logic [2:0]            w_occ;
  logic [1:0]            w_tail;
  assign w_mem_cnt  = r_wr_ptr - r_rd_ptr;
  assign full       = w_mem_cnt[addr_width];
  assign s_ready    = ~full;
  assign w_push     = s_valid & s_ready;
  assign m_valid    = r_buf_cnt != 2'd0;
  assign m_data     = r_buf0;
  assign w_pop      = m_valid & m_ready;
  // occupancy the buffer will reach once the outstanding read lands
  assign w_occ      = {1'b0, r_buf_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue    = (w_mem_cnt != '0) && (w_occ < 3'd2);
  assign w_tail     = r_buf_cnt - {1'b0, w_pop};
  assign ram_a      = w_push;
  assign ram_addr_a = r_wr_ptr[addr_width-1:0];
  assign ram_data_a = s_data;
  assign ram_b      = 1'b0;
  assign ram_addr_b = r_rd_ptr[addr_width-1:0];
  assign count      = {1'b0, w_mem_cnt} + {{(addr_width+1){1'b0}}, r_inflight} + {{addr_width{1'b0}}, r_buf_cnt};
  assign empty      = count == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_inflight <= 1'b0;
      r_buf_cnt  <= '0;
      r_buf0     <= '0;
      r_buf1     <= '0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + {{addr_width{1'b0}}, w_push};
      r_rd_ptr   <= r_rd_ptr + {{addr_width{1'b0}}, w_issue};
      r_inflight <= w_issue;
      r_buf_cnt  <= w_occ[1:0];
      r_buf0     <= (r_inflight && w_tail == 2'd0) ? ram_rdata_b : w_pop ? r_buf1 : r_buf0;
      r_buf1     <= (r_inflight && w_tail == 2'd1) ? ram_rdata_b : r_buf1;
    end
  end
`ifdef DPRAM_FIFO_HWM_EN
  logic [addr_width+1:0] w_count_nxt;
  assign w_count_nxt = count + {{(addr_width+1){1'b0}}, w_push} - {{(addr_width+1){1'b0}}, w_pop};
  always_ff @(posedge clk) begin
    if (rst) hwm <= '0;
    else if (hwm_clr) hwm <= count;
    else if (w_count_nxt > hwm) hwm <= w_count_nxt;
  end
`endif
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb_dpram_fifo_ctrl: directed self-checking bench with a behavioural registered-read RAM.
module tb_dpram_fifo_ctrl;
  localparam int dw = 8;
  localparam int aw = 6;
  logic          clk = 0;
  logic          rst = 0;
  logic          s_valid = 0, m_ready = 0;
  logic [dw-1:0] s_data = 0;
  logic          s_ready, m_valid, ram_a, ram_b, full, empty;
  logic [dw-1:0] m_data, ram_data_a, ram_rdata_b;
  logic [aw-1:0] ram_addr_a, ram_addr_b;
  logic [aw+1:0] count;
  logic [dw-1:0] mem [0:(1<<aw)-1];
  int            n_chk = 0, n_err = 0;
`ifdef DPRAM_FIFO_HWM_EN
  logic          hwm_clr = 0;
  logic [aw+1:0] hwm;
`endif
  dpram_fifo_ctrl #(.data_width(dw), .addr_width(aw)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ram_a(ram_a), .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a),
    .ram_b(ram_b), .ram_addr_b(ram_addr_b), .ram_rdata_b(ram_rdata_b),
    .count(count), .full(full), .empty(empty)
`ifdef DPRAM_FIFO_HWM_EN
    , .hwm_clr(hwm_clr), .hwm(hwm)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_a) mem[ram_addr_a] <= ram_data_a;
    ram_rdata_b <= mem[ram_addr_b];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1; s_valid = 0; m_ready = 0;
    tick();
    rst = 0;
  endtask
  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      s_valid = 1; s_data = dw'(base + i);
      tick();
    end
    s_valid = 0;
  endtask
  task automatic drain(input int n, input int base);
    m_ready = 1;
    for (int i = 0; i < n; i++) begin
      int cyc = 0;
      #1;
      while (!m_valid && cyc < 20) begin tick(); cyc++; end
      chk("drain_valid", 32'(m_valid), 1);
      chk("drain_data", 32'(m_data), 32'(dw'(base + i)));
      tick();
    end
    m_ready = 0;
  endtask
  logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
  initial begin
    int wi, ri, first, last;
    logic pushed;
    do_reset();
    chk("rst_state", {s_ready, m_valid, empty, full, ram_a, ram_b, 2'b0, 8'(count), m_data}, {8'b10100000, 8'h00, 8'h00});
    for (int i = 0; i < 10; i++) begin
      chk("idle", {s_ready, m_valid, empty, ram_a, 4'b0, 8'(count)}, {8'b10100000, 8'h00});
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      s_valid = 1; s_data = vals[i]; #1;
      chk("wr_en", 32'(ram_a), 1);
      chk("wr_addr", 32'(ram_addr_a), 32'(i));
      chk("wr_data", 32'(ram_data_a), 32'(vals[i]));
      tick();
      chk("lat_mvalid", 32'(m_valid), 32'(i == 2));
    end
    s_valid = 0; #1;
    chk("wr_idle", 32'(ram_a), 0);
    tick(); tick(); tick();
    chk("cnt3", 32'(count), 3);
    chk("bufcnt2", 32'(dut.r_buf_cnt), 2);
    chk("head", 32'(m_data), 32'h11);
    tick();
    chk("hold_data", 32'(m_data), 32'h11);
    chk("hold_valid", 32'(m_valid), 1);
    m_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("pop3_valid", 32'(m_valid), 1);
      chk("pop3_data", 32'(m_data), 32'(vals[i]));
      tick();
    end
    m_ready = 0;
    tick();
    chk("empty3", {31'b0, empty}, 1);
    do_reset();
    push_n(66, 0);
    tick(); tick();
    chk("fill_count", 32'(count), 66);
    chk("fill_full", 32'(full), 1);
    chk("fill_sready", 32'(s_ready), 0);
    s_valid = 1; s_data = 8'hEE; #1;
    chk("fill_no_write", 32'(ram_a), 0);
    tick();
    s_valid = 0;
    chk("fill_count_hold", 32'(count), 66);
    drain(66, 0);
    tick();
    chk("fill_drained", 32'(empty), 1);
    do_reset();
    wi = 0; ri = 0; first = -1; last = -1;
    for (int c = 0; c < 400 && ri < 200; c++) begin
      s_valid = wi < 200; s_data = wi[7:0]; m_ready = 1; #1;
      pushed = s_valid & s_ready;
      if (m_valid) begin
        chk("stream", 32'(m_data), 32'(ri[7:0]));
        if (ri == 0) first = c;
        last = c;
        ri++;
      end
      tick();
      if (pushed) wi++;
    end
    s_valid = 0; m_ready = 0;
    chk("stream_count", 32'(ri), 200);
    chk("stream_rate", 32'(last - first), 199);
    tick();
    chk("stream_empty", 32'(empty), 1);
    do_reset();
    push_n(10, 8'h40);
    tick(); tick(); tick();
    chk("mid_count10", 32'(count), 10);
    m_ready = 1; #1;
    chk("mid_head", 32'(m_data), 32'h40);
    tick();
    m_ready = 0;
    chk("mid_inflight", 32'(count), 9);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst", {m_valid, empty, 6'b0, 8'(count)}, {8'b01000000, 8'h00});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_quiet", {m_valid, 7'b0, 8'(count)}, 16'h0000);
    end
    s_valid = 1; s_data = 8'hA5;
    tick();
    s_valid = 0;
    tick(); tick();
    chk("a5_valid", 32'(m_valid), 1);
    chk("a5_data", 32'(m_data), 32'hA5);
    chk("a5_count", 32'(count), 1);
    m_ready = 1;
    tick();
    m_ready = 0;
    tick(); tick(); tick();
    chk("a5_alone", {m_valid, empty, 6'b0, 8'(count)}, {8'b01000000, 8'h00});
`ifdef DPRAM_FIFO_HWM_EN
    do_reset();
    chk("hwm_rst", 32'(hwm), 0);
    push_n(20, 8'h80);
    tick(); tick(); tick();
    drain(20, 8'h80);
    tick();
    chk("hwm_peak", 32'(hwm), 20);
    chk("hwm_cnt0", 32'(count), 0);
    hwm_clr = 1;
    tick();
    hwm_clr = 0;
    chk("hwm_clr", 32'(hwm), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/dpram_fifo_ctrl.md
Name: dpram_fifo_ctrl

Overview:
- Synchronous FIFO controller placed directly upstream of the team's dual-port RAM (`dual_port_ram`, `data_width`/`addr_width` parameters).
- Converts a valid/ready write stream into RAM port-A write commands, and RAM port-B reads into a valid/ready output stream.
- Hides the RAM's 1-cycle registered read latency with a 2-entry output buffer, so throughput is one word per clock in each direction.

Parameters:
- data_width, 8, word width; must match the RAM instance.
- addr_width, 6, RAM address width; RAM depth = 2**addr_width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  controller can accept a word.
- s_data  in  data_width  upstream word.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts the word.
- m_data  out  data_width  output word (head of the output buffer).
- ram_a  out  1  RAM port-A write enable (1 = write).
- ram_addr_a  out  addr_width  RAM port-A address.
- ram_data_a  out  data_width  RAM port-A write data.
- ram_b  out  1  RAM port-B mode; tied 0 (read-only).
- ram_addr_b  out  addr_width  RAM port-B address.
- ram_rdata_b  in  data_width  RAM port-B registered read data.
- count  out  addr_width+2  total words held.
- full  out  1  RAM region full.
- empty  out  1  count == 0.

Behaviour:
- Clock and reset: one clock domain (clk); rst is synchronous and active-high.
- Reset values, effective the first edge with rst=1:
  - wr_ptr = 0, rd_ptr = 0 (each addr_width+1 bits).
  - inflight = 0, buf_cnt = 0, buffer data = 0.
  - m_valid = 0, m_data = 0, count = 0, empty = 1, full = 0, s_ready = 1, ram_a = 0.
- Reset mid-operation: all stored and in-flight words are discarded. RAM contents are ignored; the RAM's X outputs after reset are never sampled because inflight = 0.
- Occupancy terms:
  - mem_cnt = wr_ptr - rd_ptr, modulo 2**(addr_width+1).
  - full = (mem_cnt == 2**addr_width).
  - count = mem_cnt + inflight + buf_cnt. Maximum is 2**addr_width + 2.
- Write path (combinational from registered state):
  - push = s_valid & s_ready, where s_ready = ~full.
  - ram_a = push, ram_addr_a = wr_ptr[addr_width-1:0], ram_data_a = s_data.
  - wr_ptr increments on push and wraps naturally.
- Read issue:
  - pop = m_valid & m_ready.
  - issue = (mem_cnt != 0) & (buf_cnt + inflight - pop < 2).
  - ram_addr_b = rd_ptr[addr_width-1:0]. rd_ptr increments on issue.
  - inflight <= issue.
- Read return: when inflight = 1, ram_rdata_b is captured into the buffer tail that cycle. One-cycle latency from issue to capture.
- Output buffer:
  - 2-entry FIFO; m_valid = (buf_cnt != 0); m_data = head entry.
  - Capture and pop in the same cycle are both honoured: buf_cnt unchanged, data shifts.
- Latency: a push into an empty controller gives m_valid = 1 three cycles later (write edge, issue edge, capture edge).
- No read/write address collision:
  - A read requires mem_cnt != 0 and a write requires mem_cnt != depth.
  - So wr_ptr and rd_ptr never alias in the same cycle while both are active.
- Simultaneous push and issue are allowed. mem_cnt changes by push - issue.
- Wrap-around: pointers carry one extra MSB, which distinguishes full from empty at addr equality.
- Output stability: m_data and m_valid hold while m_valid & ~m_ready.

Optional Feature:
- Macro: DPRAM_FIFO_HWM_EN.
- When defined:
  - Adds output port hwm (addr_width+2 bits).
  - hwm is a high-water-mark register, reset to 0, updated each cycle to max(hwm, count of the next state).
  - A clear input hwm_clr (1 bit) synchronously loads hwm with the current count.
- When undefined: neither port exists and no logic is generated; all other behaviour is identical.

Test Plan:
- Reset then idle → s_ready=1, m_valid=0, empty=1, count=0, ram_a=0 for 10 cycles.
- Push 0x11, 0x22, 0x33 on back-to-back cycles with m_ready=0:
  - ram_a pulses at addresses 0, 1, 2.
  - m_valid rises 3 cycles after the first push.
  - count settles at 3, and buf_cnt reaches 2.
- Fill with 66 pushes (addr_width=6), m_ready=0 → full=1, s_ready=0 at count=66; a further s_valid is held off, with no ram_a.
- Continuous push and pop with m_ready=1 for 200 words → output equals input order, wrap past address 63 is correct, sustained 1 word/cycle after fill.
- Assert rst for 1 cycle with 10 words stored and a read in flight → next cycle count=0, m_valid=0; a subsequent push of 0xA5 emerges alone.
- With DPRAM_FIFO_HWM_EN: push 20, pop all → hwm=20. Pulse hwm_clr at count=0 → hwm=0.
